int_dispatch: RTL and testbench

- CPU-side responder to the priority interrupt encoder: consumes its level `int_req`/`int_num` pair and redirects the fetch PC to the vector of the winning source.
- Saves the resume PC and returns one-hot acknowledge pulses that clear the serviced request line.
- Blocks further entries until a return instruction retires, then applies a programmable hold-off before the next interrupt may be taken.
- Sits between the encoder, the CSR enable bit and the fetch/PC-select logic.

---
 rtl/int_dispatch.sv | 120 ++++++++++++
 tb/tb_int_dispatch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/int_dispatch.sv
// rtl/int_dispatch.sv - interrupt entry/return dispatcher driving the fetch PC redirect
//
// Takes the winning request from the priority encoder, redirects fetch to that
// source's vector, saves the resume PC and pulses a one-hot ack to clear the
// serviced line. Further entries are blocked until a return retires, followed by
// a programmable hold-off.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   int_req, int_num    level request and index of the highest-priority line
//   int_en              global interrupt enable
//   stall               pipeline cannot accept a redirect this cycle
//   ret                 return-from-interrupt retiring this cycle
//   pc_next             resume address captured on entry
//   redirect            one-cycle pulse: fetch loads redirect_pc
//   redirect_pc         redirect target
//   epc                 saved resume PC
//   ack                 one-hot one-cycle acknowledge to the serviced source
//   in_service          high while servicing an interrupt
//   cur_num             index of the interrupt being serviced
module int_dispatch #(
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int unsigned VEC_STRIDE = 4,
  parameter int unsigned HOLDOFF    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req,
  input  logic [2:0]  int_num,
  input  logic        int_en,
  input  logic        stall,
  input  logic        ret,
  input  logic [31:0] pc_next,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc,
  output logic [7:0]  ack,
  output logic        in_service,
  output logic [2:0]  cur_num
);

  typedef enum logic [1:0] {
    IDLE,
    SERVICE,
    HOLD
  } state_t;

  localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        redirect_q;
  logic [31:0] redirect_pc_q;
  logic [31:0] epc_q;
  logic [7:0]  ack_q;
  logic        in_service_q;
  logic [2:0]  cur_num_q;

  // Vector address wraps modulo 2^32 by construction of the 32-bit sum.
  logic [31:0] vec_addr;
  assign vec_addr = VEC_BASE + 32'(int_num) * VEC_STRIDE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
      epc_q         <= 32'd0;
      ack_q         <= 8'd0;
      in_service_q  <= 1'b0;
      cur_num_q     <= 3'd0;
    end else begin
      // Pulse outputs default low; each event below raises them for one cycle.
      redirect_q <= 1'b0;
      ack_q      <= 8'd0;
      case (state_q)
        IDLE: begin
          if (int_req && int_en && !stall) begin
            state_q       <= SERVICE;
            epc_q         <= pc_next;
            cur_num_q     <= int_num;
            redirect_pc_q <= vec_addr;
            redirect_q    <= 1'b1;
            ack_q         <= 8'd1 << int_num;
            in_service_q  <= 1'b1;
          end
        end
        SERVICE: begin
          // Requests and the enable are deliberately ignored here: no nesting.
          if (ret && !stall) begin
            state_q       <= HOLD;
            redirect_q    <= 1'b1;
            redirect_pc_q <= epc_q;
            in_service_q  <= 1'b0;
            cnt_q         <= HOLD_INIT;
          end
        end
        HOLD: begin
          // The edge that consumes the last hold-off cycle also returns to IDLE.
          if (cnt_q <= 4'd1) begin
            cnt_q   <= 4'd0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign epc         = epc_q;
  assign ack         = ack_q;
  assign in_service  = in_service_q;
  assign cur_num     = cur_num_q;

endmodule

// File: tb/tb_int_dispatch.sv
// tb/tb_int_dispatch.sv - randomized and directed bench for int_dispatch against a behavioural model
module tb_int_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_req;
  logic [2:0]  int_num;
  logic        int_en;
  logic        stall;
  logic        ret;
  logic [31:0] pc_next;

  logic        red   [3];
  logic [31:0] rpc   [3];
  logic [31:0] epcv  [3];
  logic [7:0]  ackv  [3];
  logic        insvc [3];
  logic [2:0]  cnum  [3];

  always #5 clk = ~clk;

  // Three configurations share one stimulus stream: default, long hold-off, wrapping base.
  int_dispatch u0 (
    .clk(clk), .rst(rst), .int_req(int_req), .int_num(int_num), .int_en(int_en),
    .stall(stall), .ret(ret), .pc_next(pc_next), .redirect(red[0]),
    .redirect_pc(rpc[0]), .epc(epcv[0]), .ack(ackv[0]), .in_service(insvc[0]),
    .cur_num(cnum[0])
  );

  int_dispatch #(.HOLDOFF(3)) u1 (
    .clk(clk), .rst(rst), .int_req(int_req), .int_num(int_num), .int_en(int_en),
    .stall(stall), .ret(ret), .pc_next(pc_next), .redirect(red[1]),
    .redirect_pc(rpc[1]), .epc(epcv[1]), .ack(ackv[1]), .in_service(insvc[1]),
    .cur_num(cnum[1])
  );

  int_dispatch #(.VEC_BASE(32'hFFFF_FFF0)) u2 (
    .clk(clk), .rst(rst), .int_req(int_req), .int_num(int_num), .int_en(int_en),
    .stall(stall), .ret(ret), .pc_next(pc_next), .redirect(red[2]),
    .redirect_pc(rpc[2]), .epc(epcv[2]), .ack(ackv[2]), .in_service(insvc[2]),
    .cur_num(cnum[2])
  );

  // Model configuration per instance.
  logic [31:0] cfg_base [3] = '{32'h0000_0100, 32'h0000_0100, 32'hFFFF_FFF0};
  int          cfg_hold [3] = '{1, 3, 1};

  // Model state: servicing flag, cycles of hold-off still to wait, saved context.
  bit          m_svc  [3];
  int          m_wait [3];
  logic [31:0] m_epc  [3];
  logic [2:0]  m_num  [3];
  bit          e_red  [3];
  logic [31:0] e_rpc  [3];
  logic [7:0]  e_ack  [3];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_svc[k]  = 0;
      m_wait[k] = 0;
      m_epc[k]  = 32'd0;
      m_num[k]  = 3'd0;
      e_red[k]  = 0;
      e_rpc[k]  = 32'd0;
      e_ack[k]  = 8'd0;
    end
  endtask

  // Predicts the outputs after the next rising edge from the currently driven inputs.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      e_red[k] = 0;
      e_ack[k] = 8'd0;
      if (m_wait[k] > 0) begin
        m_wait[k]--;
      end else if (m_svc[k]) begin
        if (ret && !stall) begin
          e_red[k]  = 1;
          e_rpc[k]  = m_epc[k];
          m_svc[k]  = 0;
          m_wait[k] = cfg_hold[k];
        end
      end else if (int_req && int_en && !stall) begin
        m_svc[k] = 1;
        m_epc[k] = pc_next;
        m_num[k] = int_num;
        e_red[k] = 1;
        e_rpc[k] = cfg_base[k] + 32'(int_num) * 32'd4;
        e_ack[k] = 8'(1 << int_num);
      end
    end
  endtask

  task automatic compare_all(input string ph, input bit full);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s/u%0d/redirect", ph, k), 32'(red[k]), 32'(e_red[k]));
      check($sformatf("%s/u%0d/ack", ph, k), 32'(ackv[k]), 32'(e_ack[k]));
      check($sformatf("%s/u%0d/in_service", ph, k), 32'(insvc[k]), 32'(m_svc[k]));
      check($sformatf("%s/u%0d/epc", ph, k), epcv[k], m_epc[k]);
      check($sformatf("%s/u%0d/cur_num", ph, k), 32'(cnum[k]), 32'(m_num[k]));
      if (full || e_red[k])
        check($sformatf("%s/u%0d/redirect_pc", ph, k), rpc[k], e_rpc[k]);
    end
  endtask

  task automatic cycle(input string ph, input logic rq, input logic [2:0] num, input logic en,
                       input logic st, input logic rt, input logic [31:0] pc);
    int_req = rq;
    int_num = num;
    int_en  = en;
    stall   = st;
    ret     = rt;
    pc_next = pc;
    model_step();
    @(posedge clk);
    #1;
    compare_all(ph, 1'b0);
  endtask

  task automatic idle_cycles(input string ph, input int n);
    for (int i = 0; i < n; i++) cycle(ph, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    int_req = 1'b0;
    int_num = 3'd0;
    int_en  = 1'b0;
    stall   = 1'b0;
    ret     = 1'b0;
    pc_next = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset", 1'b1);
    rst = 1'b0;

    // Basic entry and return.
    cycle("basic_entry", 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 32'h0000_2040);
    check("basic_vec_lit", rpc[0], 32'h0000_010C);
    check("basic_ack_lit", 32'(ackv[0]), 32'h08);
    cycle("basic_wait", 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    cycle("basic_ret", 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 32'd0);
    check("basic_ret_lit", rpc[0], 32'h0000_2040);
    idle_cycles("basic_idle", 4);

    // Stall gating on entry and on return.
    repeat (3) cycle("stall_entry", 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 32'h0000_3000);
    cycle("stall_release", 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 32'h0000_3004);
    check("stall_vec_lit", rpc[0], 32'h0000_0114);
    check("stall_ack_lit", 32'(ackv[0]), 32'h20);
    repeat (2) cycle("stall_ret", 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 32'd0);
    cycle("stall_ret_go", 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 32'd0);
    idle_cycles("stall_idle", 4);

    // Enable masking with a priority change before enable rises.
    repeat (2) cycle("mask", 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 32'h0000_4000);
    cycle("mask_chg", 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 32'h0000_4004);
    cycle("mask_en", 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 32'h0000_4008);
    check("mask_vec_lit", rpc[0], 32'h0000_0104);
    check("mask_ack_lit", 32'(ackv[0]), 32'h02);
    cycle("mask_en_off", 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 32'd0);
    cycle("mask_ret", 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 32'd0);
    idle_cycles("mask_idle", 4);

    // Held request through service and hold-off; re-entry only after the hold-off.
    cycle("hold_entry", 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 32'h0000_5000);
    cycle("hold_svc", 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 32'h0000_5004);
    cycle("hold_ret", 1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 32'h0000_5008);
    repeat (4) cycle("hold_wait", 1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 32'h0000_500C);
    check("hold_vec_lit", rpc[1], 32'h0000_0108);
    cycle("hold_ret2", 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 32'd0);
    idle_cycles("hold_idle", 4);
    repeat (3) cycle("ret_in_idle", 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 32'd0);

    // Vector wrap-around on the high-base instance.
    cycle("wrap_entry", 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 32'h0000_6000);
    check("wrap_vec_lit", rpc[2], 32'h0000_000C);
    cycle("wrap_ret", 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 32'd0);
    idle_cycles("wrap_idle", 4);

    // Asynchronous reset mid-service: outputs clear without a clock edge.
    cycle("rst_entry", 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 32'h1234_5678);
    check("rst_epc_lit", epcv[0], 32'h1234_5678);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst", 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle("post_rst", 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 32'h0000_7000);
    check("post_rst_lit", rpc[0], 32'h0000_0100);
    cycle("post_rst_ret", 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle("rand",
            1'($urandom_range(0, 99) < 55),
            3'($urandom_range(0, 7)),
            1'($urandom_range(0, 99) < 80),
            1'($urandom_range(0, 99) < 25),
            1'($urandom_range(0, 99) < 30),
            $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
